// File: rtl/matrix_store.sv
// matrix_store: 25 places (row x col dims 1..5) x 2 slots of 200-bit matrices,
// with a 2-bit occupancy count per place and registered one-cycle responses.
// Optional feature macro: MATRIX_STORE_CLEAR_EN adds clr_all/busy and a
// 25-cycle count-clearing sweep (S_CLR).
module matrix_store (
  input  logic         clk,
  input  logic         rst,
`ifdef MATRIX_STORE_CLEAR_EN
  input  logic         clr_all,
  output logic         busy,
`endif
  input  logic         wr_en,
  input  logic [2:0]   wr_row,
  input  logic [2:0]   wr_col,
  input  logic [199:0] wr_data_flow,
  output logic         wr_done,
  output logic         wr_err,
  input  logic         read_en,
  input  logic [2:0]   rd_row,
  input  logic [2:0]   rd_col,
  input  logic [1:0]   rd_mat_index,
  output logic [199:0] rd_data_flow,
  output logic         rd_ready,
  output logic         err_rd,
  output logic [49:0]  info_table,
  output logic [5:0]   total_cnt
);
  localparam int NP = 25;
  localparam int DW = 200;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RESP = 2'd1;
`ifdef MATRIX_STORE_CLEAR_EN
  localparam logic [1:0] S_CLR  = 2'd2;
`endif

  typedef struct packed {
    logic wr_done;
    logic wr_err;
    logic rd_ready;
    logic err_rd;
  } resp_t;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q [NP];
  logic [1:0]    cnt_d [NP];
  logic [DW-1:0] mem0_q [NP];
  logic [DW-1:0] mem1_q [NP];
  resp_t         resp_q, resp_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
`ifdef MATRIX_STORE_CLEAR_EN
  logic [4:0]    clr_idx_q, clr_idx_d;
`endif

  logic          req_blk;
  logic          wr_ok, rd_dim_ok, rd_ok;
  logic [4:0]    wr_p, rd_p;
  logic [1:0]    wr_cnt;
  logic          mem_we;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd5);
  endfunction

  function automatic logic [4:0] place(input logic [2:0] row, input logic [2:0] col);
    logic [4:0] r, c;
    r = {2'b00, row} - 5'd1;
    c = {2'b00, col} - 5'd1;
    return r * 5'd5 + c;
  endfunction

  // Request decode: legality, place index and read selection on pre-write state
  always_comb begin
`ifdef MATRIX_STORE_CLEAR_EN
    req_blk = (state_q == S_CLR) | clr_all;
`else
    req_blk = 1'b0;
`endif
    wr_ok     = dim_ok(wr_row) & dim_ok(wr_col) & ~req_blk;
    wr_p      = wr_ok ? place(wr_row, wr_col) : 5'd0;
    wr_cnt    = cnt_q[wr_p];
    mem_we    = wr_en & wr_ok;
    rd_dim_ok = dim_ok(rd_row) & dim_ok(rd_col);
    rd_p      = rd_dim_ok ? place(rd_row, rd_col) : 5'd0;
    rd_ok     = rd_dim_ok & ~req_blk & (rd_mat_index < cnt_q[rd_p]);
  end

  // Response pulses and read data; data holds until the next read response
  always_comb begin
    resp_d          = '0;
    resp_d.wr_done  = wr_en & wr_ok;
    resp_d.wr_err   = wr_en & ~wr_ok;
    resp_d.rd_ready = read_en & rd_ok;
    resp_d.err_rd   = read_en & ~rd_ok;
    rd_data_d       = rd_data_q;
    if (resp_d.rd_ready)
      rd_data_d = rd_mat_index[0] ? mem1_q[rd_p] : mem0_q[rd_p];
    else if (resp_d.err_rd)
      rd_data_d = '0;
  end

  // Per-place counts: increment until full, saturate at 2 (eviction), sweep-clear
  always_comb begin
    for (int i = 0; i < NP; i++) cnt_d[i] = cnt_q[i];
    if (mem_we && wr_cnt != 2'd2) cnt_d[wr_p] = wr_cnt + 2'd1;
`ifdef MATRIX_STORE_CLEAR_EN
    if (state_q == S_CLR) cnt_d[clr_idx_q] = 2'd0;
`endif
  end

  // Response FSM; S_RESP persists while requests keep arriving
  always_comb begin
    state_d = (read_en | wr_en) ? S_RESP : S_IDLE;
`ifdef MATRIX_STORE_CLEAR_EN
    clr_idx_d = 5'd0;
    if (state_q == S_CLR) begin
      clr_idx_d = clr_idx_q + 5'd1;
      if (clr_idx_q != 5'd24) state_d = S_CLR;
    end else if (clr_all) begin
      state_d = S_CLR;
    end
`endif
  end

  // Slot storage: no reset needed, counts gate visibility
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (wr_cnt == 2'd2) begin
        mem0_q[wr_p] <= mem1_q[wr_p];
        mem1_q[wr_p] <= wr_data_flow;
      end else if (wr_cnt == 2'd0) begin
        mem0_q[wr_p] <= wr_data_flow;
      end else begin
        mem1_q[wr_p] <= wr_data_flow;
      end
    end
  end

  // Control state with synchronous reset; in-flight responses are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      resp_q    <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < NP; i++) cnt_q[i] <= 2'd0;
`ifdef MATRIX_STORE_CLEAR_EN
      clr_idx_q <= 5'd0;
`endif
    end else begin
      state_q   <= state_d;
      resp_q    <= resp_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
`ifdef MATRIX_STORE_CLEAR_EN
      clr_idx_q <= clr_idx_d;
`endif
    end
  end

  // Outputs forced quiet while rst is high so a pending response never escapes
  always_comb begin
    wr_done      = resp_q.wr_done  & ~rst;
    wr_err       = resp_q.wr_err   & ~rst;
    rd_ready     = resp_q.rd_ready & ~rst;
    err_rd       = resp_q.err_rd   & ~rst;
    rd_data_flow = rst ? '0 : rd_data_q;
    info_table   = '0;
    total_cnt    = '0;
    for (int p = 0; p < NP; p++) begin
      info_table[(24-p)*2 +: 2] = rst ? 2'd0 : cnt_q[p];
      total_cnt = total_cnt + (rst ? 6'd0 : {4'd0, cnt_q[p]});
    end
`ifdef MATRIX_STORE_CLEAR_EN
    busy = (state_q == S_CLR) & ~rst;
`endif
  end

endmodule

// File: tb/tb_matrix_store.sv
// Scoreboard bench for matrix_store; covers the clear sweep when
// MATRIX_STORE_CLEAR_EN is defined.
module tb_matrix_store;
  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en, read_en;
  logic [2:0]   wr_row, wr_col, rd_row, rd_col;
  logic [1:0]   rd_mat_index;
  logic [199:0] wr_data_flow, rd_data_flow;
  logic         wr_done, wr_err, rd_ready, err_rd;
  logic [49:0]  info_table;
  logic [5:0]   total_cnt;
`ifdef MATRIX_STORE_CLEAR_EN
  logic         clr_all, busy;
`endif

  always #5 clk = ~clk;

  matrix_store dut (
    .clk(clk), .rst(rst),
`ifdef MATRIX_STORE_CLEAR_EN
    .clr_all(clr_all), .busy(busy),
`endif
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data_flow(wr_data_flow),
    .wr_done(wr_done), .wr_err(wr_err),
    .read_en(read_en), .rd_row(rd_row), .rd_col(rd_col), .rd_mat_index(rd_mat_index),
    .rd_data_flow(rd_data_flow), .rd_ready(rd_ready), .err_rd(err_rd),
    .info_table(info_table), .total_cnt(total_cnt)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { bit ok; logic [199:0] data; } rsp_t;
  rsp_t rd_q[$];
  bit   wr_q[$];

  int           m_cnt [25];
  logic [199:0] m_s0 [25];
  logic [199:0] m_s1 [25];
  logic [199:0] last_rd;
  bit           clr_active;

  function automatic bit legal(int r, int c);
    return r >= 1 && r <= 5 && c >= 1 && c <= 5;
  endfunction

  function automatic int pl(int r, int c);
    return (r - 1) * 5 + (c - 1);
  endfunction

  function automatic logic [199:0] mkdata(int r, int c);
    logic [199:0] d;
    d = '0;
    if (legal(r, c))
      for (int k = 0; k < r * c; k++) d[8*k +: 8] = 8'($urandom);
    return d;
  endfunction

  function automatic logic [49:0] exp_info();
    logic [49:0] v;
    v = '0;
    for (int p = 0; p < 25; p++) v[(24-p)*2 +: 2] = 2'(m_cnt[p]);
    return v;
  endfunction

  function automatic int exp_total();
    int s;
    s = 0;
    for (int p = 0; p < 25; p++) s += m_cnt[p];
    return s;
  endfunction

  // call before drive_wr in the same cycle: read sees pre-write model
  task automatic drive_rd(int r, int c, int idx);
    rsp_t e;
    read_en = 1'b1; rd_row = 3'(r); rd_col = 3'(c); rd_mat_index = 2'(idx);
    e.ok = legal(r, c) && !clr_active && idx < m_cnt[legal(r, c) ? pl(r, c) : 0];
    e.data = '0;
    if (e.ok) e.data = (idx == 0) ? m_s0[pl(r, c)] : m_s1[pl(r, c)];
    rd_q.push_back(e);
  endtask

  task automatic drive_wr(int r, int c, logic [199:0] d);
    int p;
    wr_en = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_data_flow = d;
    if (legal(r, c) && !clr_active) begin
      p = pl(r, c);
      if (m_cnt[p] == 0) m_s0[p] = d;
      else if (m_cnt[p] == 1) m_s1[p] = d;
      else begin m_s0[p] = m_s1[p]; m_s1[p] = d; end
      if (m_cnt[p] < 2) m_cnt[p]++;
      wr_q.push_back(1'b1);
    end else begin
      wr_q.push_back(1'b0);
    end
  endtask

  task automatic tick();
    rsp_t e;
    bit   w;
    logic [1:0] exp_rp, exp_wp;
    @(posedge clk); #1;
    exp_rp = 2'b00;
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      exp_rp = e.ok ? 2'b10 : 2'b01;
      last_rd = e.data;
    end
    exp_wp = 2'b00;
    if (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      exp_wp = w ? 2'b10 : 2'b01;
    end
    chk("rd_pulse{ready,err}", {198'd0, rd_ready, err_rd}, {198'd0, exp_rp});
    chk("wr_pulse{done,err}",  {198'd0, wr_done, wr_err}, {198'd0, exp_wp});
    chk("rd_data", rd_data_flow, last_rd);
    if (!clr_active) begin
      chk("info_table", {150'd0, info_table}, {150'd0, exp_info()});
      chk("total_cnt", {194'd0, total_cnt}, 200'(exp_total()));
    end
    read_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic model_reset();
    for (int p = 0; p < 25; p++) m_cnt[p] = 0;
    last_rd = '0;
    rd_q.delete(); wr_q.delete();
  endtask

  logic [199:0] da, db, dc, dd, de;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 0; read_en = 0; wr_row = 0; wr_col = 0; rd_row = 0; rd_col = 0;
    rd_mat_index = 0; wr_data_flow = '0; clr_active = 0;
`ifdef MATRIX_STORE_CLEAR_EN
    clr_all = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pulses", {196'd0, rd_ready, err_rd, wr_done, wr_err}, 200'd0);
    chk("reset_rd_data", rd_data_flow, 200'd0);
    chk("reset_info", {150'd0, info_table}, 200'd0);
    chk("reset_total", {194'd0, total_cnt}, 200'd0);
    rst = 1'b0;

    // 2x3 A, then B, C with eviction of A
    da = mkdata(2, 3); db = mkdata(2, 3); dc = mkdata(2, 3);
    drive_wr(2, 3, da); tick();
    chk("p7_cnt_after_A", {198'd0, info_table[(24-7)*2 +: 2]}, 200'd1);
    chk("total_after_A", {194'd0, total_cnt}, 200'd1);
    drive_wr(2, 3, db); tick();
    drive_wr(2, 3, dc); tick();
    chk("p7_cnt_after_C", {198'd0, info_table[(24-7)*2 +: 2]}, 200'd2);
    chk("total_after_C", {194'd0, total_cnt}, 200'd2);

    // three back-to-back reads, then idle to see data held
    drive_rd(2, 3, 0); tick();
    chk("read_B", rd_data_flow, db);
    drive_rd(2, 3, 1); tick();
    chk("read_C", rd_data_flow, dc);
    drive_rd(2, 3, 0); tick();
    tick();
    chk("rd_hold", rd_data_flow, db);

    // error cases
    drive_rd(4, 4, 0); tick();
    drive_wr(6, 3, mkdata(5, 5)); tick();
    drive_rd(2, 3, 2); tick();
    drive_rd(0, 1, 0); tick();
    drive_wr(3, 0, mkdata(5, 5)); tick();
    drive_rd(2, 6, 1); tick();

    // simultaneous read (empty) and write same place
    dd = mkdata(3, 3);
    drive_rd(3, 3, 0); drive_wr(3, 3, dd); tick();
    drive_rd(3, 3, 0); tick();
    chk("read_D", rd_data_flow, dd);

    // read-before-write on a full place
    de = mkdata(2, 3);
    drive_rd(2, 3, 0); drive_wr(2, 3, de); tick();
    chk("rbw_read_B", rd_data_flow, db);
    drive_rd(2, 3, 0); tick();
    drive_rd(2, 3, 1); tick();
    chk("read_E", rd_data_flow, de);

    // corner places 1x1 and 5x5
    drive_wr(1, 1, mkdata(1, 1)); tick();
    drive_wr(5, 5, mkdata(5, 5)); drive_rd(1, 1, 0); tick();
    drive_rd(5, 5, 0); tick();

    // random back-to-back traffic
    for (int i = 0; i < 60; i++) begin
      int r, c;
      if ($urandom_range(0, 3) != 0) drive_rd($urandom_range(0, 6), $urandom_range(1, 5), $urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 6); c = $urandom_range(1, 6);
        drive_wr(r, c, mkdata(r, c));
      end
      tick();
    end

`ifdef MATRIX_STORE_CLEAR_EN
    // clear sweep: requests during sweep are rejected
    clr_all = 1'b1; clr_active = 1;
    drive_rd(2, 3, 0); drive_wr(2, 2, mkdata(2, 2));
    tick();
    clr_all = 1'b0;
    chk("busy_start", {199'd0, busy}, 200'd1);
    for (int k = 0; k < 25; k++) begin
      if (k % 6 == 0) begin drive_rd(2, 3, 0); drive_wr(1, 1, mkdata(1, 1)); end
      tick();
      chk("busy_sweep", {199'd0, busy}, (k <= 23) ? 200'd1 : 200'd0);
    end
    clr_active = 0;
    for (int p = 0; p < 25; p++) m_cnt[p] = 0;
    chk("clr_total", {194'd0, total_cnt}, 200'd0);
    chk("clr_info", {150'd0, info_table}, 200'd0);
    drive_wr(4, 2, mkdata(4, 2)); tick();
    drive_rd(4, 2, 0); tick();
`endif

    // reset with a read in flight: response must be suppressed
    if (m_cnt[pl(2, 3)] == 0) begin drive_wr(2, 3, mkdata(2, 3)); tick(); end
    read_en = 1'b1; rd_row = 3'd2; rd_col = 3'd3; rd_mat_index = 2'd0;
    @(posedge clk); #1;
    read_en = 1'b0; rst = 1'b1;
    #1;
    chk("rst_inflight_pulses", {196'd0, rd_ready, err_rd, wr_done, wr_err}, 200'd0);
    chk("rst_rd_data", rd_data_flow, 200'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_info", {150'd0, info_table}, 200'd0);
    chk("rst_total", {194'd0, total_cnt}, 200'd0);
    // first request right after reset release
    drive_wr(1, 2, mkdata(1, 2)); tick();
    drive_rd(2, 3, 0); tick();
    drive_rd(1, 2, 0); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
